vga_system_ram_dp: RTL and testbench



---
 rtl/vga_system_ram_dp.sv | 153 +++++++++++++++
 tb/tb_vga_system_ram_dp.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_system_ram_dp.sv
// Dual-port VGA system RAM: Avalon-MM read/write port s1, read-only scanner port s2,
// and a clear engine that fills the array with CLEAR_VALUE. Optional macro: VGA_RAM_OUTREG_EN.
module vga_system_ram_dp #(
   parameter int unsigned           DATA_WIDTH     = 32,
   parameter int unsigned           ADDR_WIDTH     = 10,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
   parameter bit                    CLEAR_ON_RESET = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_WIDTH-1:0]     s1_address,
   input  logic                      s1_chipselect,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
   input  logic [DATA_WIDTH-1:0]     s1_writedata,
   output logic [DATA_WIDTH-1:0]     s1_readdata,
   output logic                      s1_readdatavalid,
   output logic                      s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]     s2_address,
   input  logic                      s2_read,
   output logic [DATA_WIDTH-1:0]     s2_readdata,
   output logic                      s2_readdatavalid,
   input  logic                      clear_req,
   output logic                      clear_busy
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic s1_wr_en;
   logic s1_rd_en;
   logic s2_rd_en;
   logic clr_wr_en;

   // Next-state logic for the clear engine
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
            end
         end
         CLEAR: begin
            clr_addr_d = ADDR_WIDTH'(clr_addr_q + 1'b1);
            if (&clr_addr_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // A combined read+write on s1 is treated as a write only
   assign s1_wr_en  = !reset && (state_q == IDLE) && s1_chipselect && s1_write;
   assign s1_rd_en  = !reset && (state_q == IDLE) && s1_chipselect && s1_read && !s1_write;
   assign s2_rd_en  = !reset && s2_read;
   assign clr_wr_en = !reset && (state_q == CLEAR);

   always_ff @(posedge clk) begin
      if (clr_wr_en) begin
         mem_q[clr_addr_q] <= CLEAR_VALUE;
      end else if (s1_wr_en) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (s1_byteenable[b]) begin
               mem_q[s1_address][8*b +: 8] <= s1_writedata[8*b +: 8];
            end
         end
      end
   end

   logic [DATA_WIDTH-1:0] s1_rdata_q, s2_rdata_q;
   logic                  s1_rvalid_q, s2_rvalid_q;

   // First read stage: non-blocking reads return pre-write contents
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_rdata_q  <= '0;
         s1_rvalid_q <= 1'b0;
         s2_rdata_q  <= '0;
         s2_rvalid_q <= 1'b0;
      end else begin
         s1_rvalid_q <= s1_rd_en;
         s2_rvalid_q <= s2_rd_en;
         if (s1_rd_en) begin
            s1_rdata_q <= mem_q[s1_address];
         end
         if (s2_rd_en) begin
            s2_rdata_q <= mem_q[s2_address];
         end
      end
   end

`ifdef VGA_RAM_OUTREG_EN
   logic [DATA_WIDTH-1:0] s1_odata_q, s2_odata_q;
   logic                  s1_ovalid_q, s2_ovalid_q;

   // Extra output stage; data only advances with a valid result so it holds otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_odata_q  <= '0;
         s1_ovalid_q <= 1'b0;
         s2_odata_q  <= '0;
         s2_ovalid_q <= 1'b0;
      end else begin
         s1_ovalid_q <= s1_rvalid_q;
         s2_ovalid_q <= s2_rvalid_q;
         if (s1_rvalid_q) begin
            s1_odata_q <= s1_rdata_q;
         end
         if (s2_rvalid_q) begin
            s2_odata_q <= s2_rdata_q;
         end
      end
   end

   assign s1_readdata      = s1_odata_q;
   assign s1_readdatavalid = s1_ovalid_q;
   assign s2_readdata      = s2_odata_q;
   assign s2_readdatavalid = s2_ovalid_q;
`else
   assign s1_readdata      = s1_rdata_q;
   assign s1_readdatavalid = s1_rvalid_q;
   assign s2_readdata      = s2_rdata_q;
   assign s2_readdatavalid = s2_rvalid_q;
`endif

   assign s1_waitrequest = (state_q == CLEAR);
   assign clear_busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_vga_system_ram_dp.sv
// Scoreboard bench for vga_system_ram_dp (ADDR_WIDTH=4, CLEAR_VALUE=DEADBEEF, clear on reset).
module tb_vga_system_ram_dp;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 4;
   localparam logic [31:0] CV = 32'hDEADBEEF;
`ifdef VGA_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] s1_address;
   logic          s1_chipselect, s1_read, s1_write;
   logic [3:0]    s1_byteenable;
   logic [31:0]   s1_writedata, s1_readdata;
   logic          s1_readdatavalid, s1_waitrequest;
   logic [AW-1:0] s2_address;
   logic          s2_read;
   logic [31:0]   s2_readdata;
   logic          s2_readdatavalid;
   logic          clear_req, clear_busy;

   vga_system_ram_dp #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .reset(reset),
      .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
      .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
      .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
      .s1_waitrequest(s1_waitrequest),
      .s2_address(s2_address), .s2_read(s2_read), .s2_readdata(s2_readdata),
      .s2_readdatavalid(s2_readdatavalid),
      .clear_req(clear_req), .clear_busy(clear_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   logic [31:0] m_mem [16];
   logic        m_busy = 1'b0;
   logic [3:0]  m_clr  = 4'd0;
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic idle_inputs();
      s1_chipselect = 1'b0;
      s1_read       = 1'b0;
      s1_write      = 1'b0;
      s1_address    = '0;
      s1_byteenable = 4'hF;
      s1_writedata  = '0;
      s2_read       = 1'b0;
      s2_address    = '0;
      clear_req     = 1'b0;
   endtask

   task automatic s1_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      s1_chipselect = 1'b1;
      s1_write      = 1'b1;
      s1_read       = 1'b0;
      s1_address    = a;
      s1_writedata  = d;
      s1_byteenable = be;
   endtask

   task automatic s1_rd(input logic [3:0] a);
      s1_chipselect = 1'b1;
      s1_write      = 1'b0;
      s1_read       = 1'b1;
      s1_address    = a;
   endtask

   // Advance one clock: update the model with the inputs seen at this edge, then check outputs
   task automatic tick();
      exp_t       e;
      logic       busy_n;
      logic [3:0] clr_n;
      cyc++;
      if (reset) begin
         m_busy = 1'b1;
         m_clr  = 4'd0;
      end else begin
         busy_n = m_busy;
         clr_n  = m_clr;
         if (s2_read) q2.push_back('{m_mem[s2_address], cyc + LAT - 1});
         if (!m_busy) begin
            if (s1_chipselect && s1_write) begin
               for (int b = 0; b < 4; b++)
                  if (s1_byteenable[b]) m_mem[s1_address][8*b +: 8] = s1_writedata[8*b +: 8];
            end else if (s1_chipselect && s1_read) begin
               q1.push_back('{m_mem[s1_address], cyc + LAT - 1});
            end
            if (clear_req) begin
               busy_n = 1'b1;
               clr_n  = 4'd0;
            end
         end else begin
            m_mem[m_clr] = CV;
            if (m_clr == 4'd15) busy_n = 1'b0;
            clr_n = m_clr + 4'd1;
         end
         m_busy = busy_n;
         m_clr  = clr_n;
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (clear_busy !== m_busy || s1_waitrequest !== m_busy) begin
         errors++;
         $display("FAIL busy cyc=%0d got busy=%b wait=%b expected %b", cyc, clear_busy, s1_waitrequest, m_busy);
      end
      if (s1_readdatavalid === 1'b1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL s1_unexpected_valid cyc=%0d got %h expected no result", cyc, s1_readdata);
         end else begin
            e = q1.pop_front();
            if (s1_readdata !== e.data || cyc != e.due) begin
               errors++;
               $display("FAIL s1_read cyc=%0d got %h expected %h due cyc %0d", cyc, s1_readdata, e.data, e.due);
            end
         end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
         checks++;
         errors++;
         e = q1.pop_front();
         $display("FAIL s1_missing_valid cyc=%0d got valid=%b expected data %h", cyc, s1_readdatavalid, e.data);
      end
      if (s2_readdatavalid === 1'b1) begin
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL s2_unexpected_valid cyc=%0d got %h expected no result", cyc, s2_readdata);
         end else begin
            e = q2.pop_front();
            if (s2_readdata !== e.data || cyc != e.due) begin
               errors++;
               $display("FAIL s2_read cyc=%0d got %h expected %h due cyc %0d", cyc, s2_readdata, e.data, e.due);
            end
         end
      end else if (q2.size() > 0 && q2[0].due <= cyc) begin
         checks++;
         errors++;
         e = q2.pop_front();
         $display("FAIL s2_missing_valid cyc=%0d got valid=%b expected data %h", cyc, s2_readdatavalid, e.data);
      end
   endtask

   task automatic drain();
      idle_inputs();
      repeat (4) tick();
   endtask

   task automatic count_busy(input string name);
      int n = 0;
      while (clear_busy === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL %s got %0d busy cycles expected 16", name, n);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if (s1_readdata !== 32'h0 || s2_readdata !== 32'h0 || s1_readdatavalid !== 1'b0 ||
          s2_readdatavalid !== 1'b0 || clear_busy !== 1'b1 || s1_waitrequest !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs got rd1=%h rd2=%h v1=%b v2=%b busy=%b wait=%b expected 0 0 0 0 1 1",
                  s1_readdata, s2_readdata, s1_readdatavalid, s2_readdatavalid, clear_busy, s1_waitrequest);
      end
      reset = 1'b0;
      count_busy("reset_clear_len");
      for (int i = 0; i < 16; i++) begin
         s1_rd(4'(i));
         tick();
      end
      drain();
   endtask

   task automatic test_byte_write();
      s1_wr(4'd5, 32'h0, 4'hF);
      tick();
      s1_wr(4'd5, 32'h11223344, 4'b0101);
      tick();
      s1_rd(4'd5);
      tick();
      drain();
      checks++;
      if (s1_readdata !== 32'h00220044 || s1_readdatavalid !== 1'b0) begin
         errors++;
         $display("FAIL byte_write_hold got %h valid=%b expected 00220044 valid=0", s1_readdata, s1_readdatavalid);
      end
   endtask

   task automatic test_read_during_write();
      s1_wr(4'd3, 32'hA5A5A5A5, 4'hF);
      s2_read    = 1'b1;
      s2_address = 4'd3;
      tick();
      s1_chipselect = 1'b0;
      s1_write      = 1'b0;
      tick();
      s2_read = 1'b0;
      // read and write together: write wins, no read result
      s1_wr(4'd4, 32'h01020304, 4'hF);
      s1_read = 1'b1;
      tick();
      s1_rd(4'd4);
      tick();
      drain();
   endtask

   task automatic test_clear_req();
      int n = 0;
      s1_wr(4'd7, 32'h12345678, 4'hF);
      clear_req = 1'b1;
      tick();
      idle_inputs();
      while (clear_busy === 1'b1 && n < 100) begin
         clear_req = (n == 5);
         if (n == 3) s1_wr(4'd2, 32'h0BAD0BAD, 4'hF);
         tick();
         n++;
      end
      clear_req = 1'b0;
      checks++;
      if (n != 16) begin
         errors++;
         $display("FAIL clear_req_len got %0d busy cycles expected 16", n);
      end
      tick();
      s1_rd(4'd7);
      tick();
      s1_rd(4'd2);
      tick();
      drain();
   endtask

   task automatic write_markers();
      for (int i = 0; i < 16; i++) begin
         s1_wr(4'(i), 32'h01010101 * 32'(i + 1), 4'hF);
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_clear();
      write_markers();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      count_busy("reset_mid_clear_len");
      for (int i = 0; i < 16; i++) begin
         s1_rd(4'(i));
         tick();
      end
      drain();
   endtask

   task automatic test_s2_during_clear();
      write_markers();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         s2_read    = 1'b1;
         s2_address = 4'((k + 15) % 16);
         tick();
      end
      s2_read = 1'b0;
      drain();
      checks++;
      if (s2_readdata !== CV) begin
         errors++;
         $display("FAIL s2_last_swept got %h expected %h", s2_readdata, CV);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_byte_write();
      test_read_during_write();
      test_clear_req();
      test_reset_mid_clear();
      test_s2_during_clear();
      checks++;
      if (q1.size() != 0 || q2.size() != 0) begin
         errors++;
         $display("FAIL leftover_expected got %0d/%0d pending expected 0/0", q1.size(), q2.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1);
   end

endmodule
